// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared sample type, accumulator width and divider helpers for pdm_playback_tx
package pdm_pkg;

    localparam int PCM_W = 16;

    typedef logic signed [PCM_W-1:0] pcm_sample_t;

    // Six guard bits above the sample keep the loop integrators clear of saturation in normal use
    function automatic int acc_width(input int data_width);
        return data_width + 6;
    endfunction

    localparam int ACC_W = acc_width(PCM_W);

    function automatic int calc_half(input int clk_freq, input int pdm_freq);
        return (clk_freq / pdm_freq) / 2;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pdm_sd_modulator.sv
// rtl/pdm_sd_modulator.sv - saturating sigma-delta loop, one PDM bit per step
// Optional second-order CIFB loop when PDM_TX_SECOND_ORDER_EN is defined.
module pdm_sd_modulator
    import pdm_pkg::*;
#(
    parameter int DATA_WIDTH = PCM_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         step,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic                         bit_out
);

    localparam int AW = acc_width(DATA_WIDTH);
    localparam int SW = AW + 2;
    localparam logic signed [SW-1:0] ACC_MAX = SW'((longint'(1) <<< (AW - 1)) - 1);
    localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX - SW'(1);
    localparam logic signed [SW-1:0] FB_MAG  = SW'(longint'(1) <<< (DATA_WIDTH - 1));

    function automatic logic signed [AW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > ACC_MAX)
            return ACC_MAX[AW-1:0];
        else if (v < ACC_MIN)
            return ACC_MIN[AW-1:0];
        else
            return v[AW-1:0];
    endfunction

    logic signed [SW-1:0] x_ext, fb, i1_sum;
    logic signed [AW-1:0] i1, i1_next;
    logic                 bit_next;

`ifdef PDM_TX_SECOND_ORDER_EN
    logic signed [SW-1:0] i2_sum;
    logic signed [AW-1:0] i2, i2_next;

    always_comb begin
        x_ext    = SW'(sample);
        fb       = bit_out ? FB_MAG : -FB_MAG;
        i1_sum   = SW'(i1) + x_ext - fb;
        i1_next  = sat(i1_sum);
        // Second stage integrates the freshly updated first stage
        i2_sum   = SW'(i2) + SW'(i1_next) - fb;
        i2_next  = sat(i2_sum);
        bit_next = ~i2_next[AW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1      <= '0;
            i2      <= '0;
            bit_out <= 1'b0;
        end else if (clear) begin
            i1      <= '0;
            i2      <= '0;
            bit_out <= 1'b0;
        end else if (step) begin
            i1      <= i1_next;
            i2      <= i2_next;
            bit_out <= bit_next;
        end
    end
`else
    always_comb begin
        x_ext    = SW'(sample);
        fb       = bit_out ? FB_MAG : -FB_MAG;
        i1_sum   = SW'(i1) + x_ext - fb;
        i1_next  = sat(i1_sum);
        bit_next = ~i1_next[AW-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1      <= '0;
            bit_out <= 1'b0;
        end else if (clear) begin
            i1      <= '0;
            bit_out <= 1'b0;
        end else if (step) begin
            i1      <= i1_next;
            bit_out <= bit_next;
        end
    end
`endif

endmodule

// File: rtl/pdm_playback_tx.sv
// rtl/pdm_playback_tx.sv - PCM FIFO, zero-order-hold interpolation and PDM clock/data generation
// Second-order modulator selected by defining PDM_TX_SECOND_ORDER_EN.
module pdm_playback_tx
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int PDM_CLK_FREQ = 3_072_000,
    parameter int OVERSAMPLE   = 64,
    parameter int DATA_WIDTH   = PCM_W,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] pcm_in,
    input  logic                         pcm_valid,
    output logic                         pcm_ready,
    output logic                         pdm_clk,
    output logic                         pdm_data,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun
);

    localparam int HALF  = calc_half(CLK_FREQ, PDM_CLK_FREQ);
    localparam int DIV_W = ptr_width(HALF);
    localparam int BIT_W = ptr_width(OVERSAMPLE);
    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int LVL_W = level_width(FIFO_DEPTH);

    logic [DIV_W-1:0]             div_cnt;
    logic [BIT_W-1:0]             bit_cnt;
    logic [PTR_W-1:0]             wr_ptr, rd_ptr;
    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] cur_sample;
    logic                         div_wrap, fall_tick, strobe, push, pop;

    assign div_wrap  = (div_cnt == DIV_W'(HALF - 1));
    // Data only moves on the falling edge so the receiver samples on a settled rising edge
    assign fall_tick = enable && pdm_clk && div_wrap;
    assign strobe    = fall_tick && (bit_cnt == BIT_W'(OVERSAMPLE - 1));
    assign pcm_ready = enable && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push      = pcm_valid && pcm_ready;
    assign pop       = strobe && (fifo_level != '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= pcm_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            pdm_clk    <= 1'b0;
            bit_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cur_sample <= '0;
            underrun   <= 1'b0;
        end else if (!enable) begin
            div_cnt    <= '0;
            pdm_clk    <= 1'b0;
            bit_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cur_sample <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= strobe && (fifo_level == '0);
            if (div_wrap) begin
                div_cnt <= '0;
                pdm_clk <= ~pdm_clk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_tick)
                bit_cnt <= strobe ? '0 : bit_cnt + BIT_W'(1);
            // On an empty strobe cur_sample simply holds its previous value
            if (pop) begin
                cur_sample <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + PTR_W'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_level <= fifo_level + LVL_W'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - LVL_W'(1);
        end
    end

    pdm_sd_modulator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mod (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!enable),
        .step    (fall_tick),
        .sample  (cur_sample),
        .bit_out (pdm_data)
    );

endmodule

// File: doc/pdm_playback_tx.md
Name: pdm_playback_tx

Overview:
PCM-to-PDM transmitter, the output-direction counterpart of the microphone capture path. Buffers PCM samples in a small FIFO and interpolates each sample by zero-order hold over OVERSAMPLE PDM bits. Converts them to a 1-bit PDM stream with a sigma-delta modulator. Generates its own pdm_clk and drives a PDM amplifier/DAC, or feeds the capture block in loopback.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency (Hz)
PDM_CLK_FREQ, 3_072_000, target PDM bit clock (Hz)
OVERSAMPLE, 64, PDM bits per PCM sample
DATA_WIDTH, 16, PCM sample width, signed two's complement
FIFO_DEPTH, 8, PCM FIFO entries (power of 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run/stop
pcm_in  in  DATA_WIDTH  signed PCM sample
pcm_valid  in  1  pcm_in valid
pcm_ready  out  1  FIFO can accept
pdm_clk  out  1  generated PDM bit clock
pdm_data  out  1  PDM bit, changes on pdm_clk falling edge
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
underrun  out  1  one-cycle pulse: sample strobe with FIFO empty

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. Reset: pdm_clk=0, pdm_data=0, pcm_ready=0, fifo_level=0, underrun=0, integrators=0, cur_sample=0, counters=0.
- Clock gen: HALF=(CLK_FREQ/PDM_CLK_FREQ)/2 (16 at defaults). Counter runs 0..HALF-1; pdm_clk toggles when the counter reaches HALF-1. Period is 2*HALF clk; duty is exactly 50%.
- Fall tick: the clk cycle in which pdm_clk is registered 1->0. Rising edge stays clean for the receiver to sample.
- On each fall tick:
  - Modulator steps using cur_sample; pdm_data is registered with the new bit in the same cycle.
  - bit_cnt increments, wrapping OVERSAMPLE-1 -> 0.
- Sample strobe: fall tick with bit_cnt==OVERSAMPLE-1. Pops the FIFO head into cur_sample, effective from the next bit.
  - If FIFO is empty at the strobe: cur_sample holds its previous value and underrun pulses high for 1 clk.
- Handshake:
  - pcm_ready = enable && fifo_level<FIFO_DEPTH, registered-state combinational.
  - Push when pcm_valid && pcm_ready. pcm_in is not consumed while ready is low.
  - Push and pop in the same cycle: both occur and level is unchanged.
  - Push into an empty FIFO on a strobe cycle: the pop sees empty (underrun fires) and the push lands.
- Modulator:
  - ACC_W=DATA_WIDTH+6 signed. x = sign-extended cur_sample. FB = out_prev ? +2^(DATA_WIDTH-1) : -2^(DATA_WIDTH-1).
  - First order: i1 += x - FB; bit = (i1 >= 0).
  - Integrators saturate at ACC_W limits, never wrap.
  - Ones density = (1 + x/2^(DATA_WIDTH-1))/2.
- enable=0:
  - pdm_clk, pdm_data forced 0.
  - Divider, bit_cnt, integrators, cur_sample cleared.
  - FIFO flushed; pcm_ready=0.
  - Deassertion mid-bit takes effect the next clk.
- enable rising: first fall tick occurs HALF*2 clk later (pdm_clk starts by going high after HALF clk).
- Reset mid-operation: all state cleared immediately. No partial samples are retained.

Optional Feature:
PDM_TX_SECOND_ORDER_EN.
- Defined: second-order CIFB modulator. i1 += x - FB; i2 += i1 - FB; bit = (i2 >= 0). Both integrators saturate.
- Undefined: first-order loop only; i2 does not exist.
- DC density law is identical in both builds.

Decomposition:
- Package pdm_pkg holds:
  - pcm_sample_t (logic signed [DATA_WIDTH-1:0]).
  - Helper localparam functions: clock-divider HALF calc and $clog2 widths.
  - ACC_W.
- Sub-module pdm_sd_modulator: integrators, saturation, bit decision, plus the optional second-order path. Interface: step strobe, sample in, bit out.
- The FIFO stays inline.

Test Plan:
1. Reset, then enable=1 -> pdm_clk period 32 clk, 16 high / 16 low. pdm_data=0 until the first fall tick. pcm_ready=1 one cycle after enable.
2. Push 0x0000 continuously -> every 64-bit window after the first has 32±1 ones. underrun never asserts.
3. Push 0x4000 continuously -> 48±2 ones per 64 bits. Push 0xC000 -> 16±2 ones. Repeat with PDM_TX_SECOND_ORDER_EN defined -> same densities.
4. With enable=1, burst-push 9 samples before the first strobe -> 8 accepted, pcm_ready low at level 8, 9th held. After the strobe, level goes 7 and the 9th is accepted.
5. Push one sample 0x2000, then stop -> strobe 2 pulses underrun for 1 clk. Density stays 40±2/64, from the held 0x2000.
6. Drop enable mid-stream -> next clk: pdm_clk=0, pdm_data=0, fifo_level=0, pcm_ready=0. Re-enable -> behaviour identical to test 1.
